// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, clear-FSM state type and byte parity helper for ram_dp_be
package ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Even parity: the stored bit makes the byte plus parity carry an even count of ones.
  function automatic logic byte_par(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// rtl/ram_clr_ctrl.sv - clear-sweep FSM and address counter; zeroes every word once per clr_start
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Terminal count is DEPTH-1; the counter is exactly ADDR_W bits so it wraps cleanly.
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - 1R1W byte-enable RAM, write-first, clear sweep; RAM_PARITY_EN adds per-byte parity
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W/8-1:0]    wr_be,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   clr_start,
  output logic                   busy,
  output logic                   par_err
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc, rd_acc, collide;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              rd_mismatch;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              par_err_q, par_err_d;

  ram_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign wr_acc  = wr_en & ~busy;
  assign rd_acc  = rd_en & ~busy;
  assign collide = wr_acc & (wr_addr == rd_addr);

  // Storage is deliberately not reset; sweep and user writes are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < NB; i++) begin
      if (collide && wr_be[i]) rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) par_mem[wr_addr][i] <= byte_par(wr_data[i*BYTE_W +: BYTE_W]);
      end
    end
  end

  always_comb begin
    rd_par      = par_mem[rd_addr];
    rd_mismatch = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (collide && wr_be[i]) rd_par[i] = byte_par(wr_data[i*BYTE_W +: BYTE_W]);
      if (rd_par[i] != byte_par(rd_word[i*BYTE_W +: BYTE_W])) rd_mismatch = 1'b1;
    end
  end
`else
  assign rd_mismatch = 1'b0;
`endif

  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? rd_word : rd_data_q;
    par_err_d  = rd_acc & rd_mismatch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      par_err_q  <= par_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign par_err  = par_err_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - directed scoreboard bench for ram_dp_be (parity case built with RAM_PARITY_EN)
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, clr_start;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_be;
  logic        rd_valid, busy, par_err;

  ram_dp_be #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_start (clr_start),
    .busy      (busy),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [256];
  logic [3:0]  bad [256];
  int          clr_cnt = 0;
  logic [32:0] exp_q [$];
  logic [31:0] last_rd = 32'h0;
  int          busy_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit          busy_m, rd_acc, wr_acc;
    logic [31:0] w;
    logic [3:0]  b;
    logic [32:0] e;
    busy_m = (clr_cnt > 0);
    rd_acc = rd_en && !busy_m;
    wr_acc = wr_en && !busy_m;
    if (rd_acc) begin
      w = model[rd_addr];
      b = bad[rd_addr];
      if (wr_acc && wr_addr == rd_addr)
        for (int i = 0; i < 4; i++)
          if (wr_be[i]) begin
            w[i*8 +: 8] = wr_data[i*8 +: 8];
            b[i] = 1'b0;
          end
      exp_q.push_back({|b, w});
    end
    if (busy_m) begin
      model[256 - clr_cnt] = 32'h0;
      bad[256 - clr_cnt]   = 4'h0;
      clr_cnt--;
    end else begin
      if (wr_acc)
        for (int i = 0; i < 4; i++)
          if (wr_be[i]) begin
            model[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
            bad[wr_addr][i] = 1'b0;
          end
      if (clr_start) clr_cnt = 256;
    end
    @(posedge clk);
    #1;
    chk("busy", {31'b0, busy}, {31'b0, clr_cnt > 0});
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, rd_acc});
    if (rd_acc) begin
      e = exp_q.pop_front();
      chk("rd_data", rd_data, e[31:0]);
      chk("par_err", {31'b0, par_err}, {31'b0, e[32]});
      last_rd = e[31:0];
    end else begin
      chk("rd_hold", rd_data, last_rd);
      chk("par_err_idle", {31'b0, par_err}, 32'h0);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
    step();
    rd_en = 1'b0;
  endtask

  task automatic wrrd(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    rd_en = 1'b1; rd_addr = a;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    wr_addr = 8'h0; rd_addr = 8'h0; wr_data = 32'h0; wr_be = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_par_err", {31'b0, par_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    wr(8'h00, 32'h12345678, 4'hF);
    rd(8'h00);

    wr(8'h10, 32'h11111111, 4'hF);
    wr(8'h10, 32'hAABBCCDD, 4'b0101);
    rd(8'h10);
    step();

    wr(8'h20, 32'h12121212, 4'hF);
    wrrd(8'h20, 32'hCAFEF00D, 4'hF);
    wr(8'h21, 32'h55555555, 4'hF);
    wrrd(8'h21, 32'h99887766, 4'b0011);
    wr(8'hFF, 32'hFEEDFACE, 4'hF);
    rd(8'hFF);
    rd(8'h00);

`ifdef RAM_PARITY_EN
    wr(8'h30, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    dut.mem[8'h30][0] = ~dut.mem[8'h30][0];
    model[8'h30][0]   = ~model[8'h30][0];
    bad[8'h30][0]     = 1'b1;
    rd(8'h30);
    rd(8'h00);
`endif

    // Write coinciding with clr_start, then hammer wr/rd for the whole sweep.
    wr_en = 1'b1; wr_addr = 8'h40; wr_data = 32'h0BADCAFE; wr_be = 4'hF;
    rd_en = 1'b0; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    busy_n = int'(busy);
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; rd_en = 1'b1;
      wr_addr = 8'($urandom); rd_addr = 8'($urandom);
      wr_data = $urandom; wr_be = 4'hF;
      step();
      busy_n += int'(busy);
    end
    chk("busy_cycles", busy_n, 32'd256);
    wr_en = 1'b0; rd_en = 1'b0;
    rd(8'h00);
    rd(8'h10);
    rd(8'h40);
    rd(8'hFF);

    // Reset in the middle of a second sweep.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; wr_addr = 8'h05; rd_addr = 8'h05;
    repeat (99) step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("mid_rst_rd_data", rd_data, 32'h0);
    chk("mid_rst_par_err", {31'b0, par_err}, 32'h0);
    clr_cnt = 0;
    last_rd = 32'h0;
    exp_q.delete();
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wr(8'h05, 32'h0BADF00D, 4'hF);
    rd(8'h05);
    wr(8'h05, 32'h00A500A5, 4'b1010);
    rd(8'h05);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
